// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the pipeline debug controller: host command bytes,
// controller state encoding, dump section codes and the word-sender states.
// -----------------------------------------------------------------------------
package debug_pkg;

    // Host command bytes (ASCII 's', 'c', 'd')
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    // Width of the per-section word index; wide enough for any legal
    // register or memory word count.
    localparam int IDX_W = 8;

    // Top-level controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_SEL,
        ST_LATCH,
        ST_SEND
    } state_e;

    // Dump sections, streamed in this order
    typedef enum logic [1:0] {
        SEC_PC,
        SEC_CYC,
        SEC_REG,
        SEC_MEM
    } section_e;

    // Word sender states
    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_e;

endpackage

// File: rtl/debug_word_sender.sv
// -----------------------------------------------------------------------------
// debug_word_sender
// Captures an NB-bit word on i_start and sends it MSB first, one byte per
// tx handshake. The word is finished when the last byte's i_tx_done arrives.
//
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_start          one-cycle pulse: capture i_word and send its top byte
//   i_word           word to send
//   i_tx_done        one-cycle pulse: previous byte finished on the link
//   o_tx_start       one-cycle pulse: send o_tx_data
//   o_tx_data        byte to send
//   o_word_done      one-cycle pulse: last byte of the word finished
// -----------------------------------------------------------------------------
module debug_word_sender
    import debug_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [NB-1:0] i_word,
    input  logic          i_tx_done,
    output logic          o_tx_start,
    output logic [7:0]    o_tx_data,
    output logic          o_word_done
);

    localparam int NBYTES = NB / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    tx_state_e        state_q;
    logic [NB-1:0]    shift_q;
    logic [CNT_W-1:0] byteCnt_q;
    logic             txStart_q;
    logic [7:0]       txData_q;

    // The word completes on the done of its final byte, so the controller can
    // move to the next word in the very next cycle.
    assign o_word_done = (state_q == TX_WAIT) && i_tx_done && (byteCnt_q == LAST_BYTE);
    assign o_tx_start  = txStart_q;
    assign o_tx_data   = txData_q;

    // Byte sequencer: the top byte leaves straight from the captured word,
    // later bytes come off the left-shifting register after each done.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            byteCnt_q <= '0;
            txStart_q <= 1'b0;
            txData_q  <= '0;
        end else begin
            txStart_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (i_start) begin
                        txStart_q <= 1'b1;
                        txData_q  <= i_word[NB-1 -: 8];
                        shift_q   <= i_word << 8;
                        byteCnt_q <= '0;
                        state_q   <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (i_tx_done) begin
                        if (byteCnt_q == LAST_BYTE) begin
                            state_q <= TX_IDLE;
                        end else begin
                            txStart_q <= 1'b1;
                            txData_q  <= shift_q[NB-1 -: 8];
                            shift_q   <= shift_q << 8;
                            byteCnt_q <= byteCnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Debug controller between the UART blocks and the MIPS pipeline. Decodes
// single-byte host commands, steps the pipeline (single step or run until
// halt) and streams a state dump: PC, cycle count, registers, memory words.
//
// Ports:
//   i_clk, i_reset     clock, asynchronous active-low reset
//   i_rx_data/done     received host byte and its valid pulse
//   i_tx_done          previous transmitted byte finished
//   i_halt             pipeline has reached HALT (level)
//   i_pc               pipeline PC
//   i_reg_data         register file read for o_debug_reg_num
//   i_mem_data         data memory read for o_debug_address
//   o_step             pipeline step enable
//   o_debug_reg_num    register select
//   o_debug_address    data memory byte address select
//   o_tx_data/start    byte to send and its start pulse
//   o_busy             controller is not idle
// -----------------------------------------------------------------------------
module debug_unit
    import debug_pkg::*;
#(
    parameter int NB        = 32,
    parameter int N_REGS    = 32,
    parameter int MEM_WORDS = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_done,
    input  logic          i_tx_done,
    input  logic          i_halt,
    input  logic [NB-1:0] i_pc,
    input  logic [NB-1:0] i_reg_data,
    input  logic [NB-1:0] i_mem_data,
    output logic          o_step,
    output logic [4:0]    o_debug_reg_num,
    output logic [NB-1:0] o_debug_address,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_start,
    output logic          o_busy
);

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(N_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

    state_e           state_q;
    section_e         sec_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [NB-1:0]    cycleCount_q;
    logic [NB-1:0]    cycleCount_d;
    logic [4:0]       regNum_q;
    logic [NB-1:0]    address_q;
    logic [NB-1:0]    dumpWord;
    logic             wordDone;

    assign idx_d        = idx_q + 1'b1;
    assign cycleCount_d = cycleCount_q + 1'b1;

    // In RUN the step is gated directly by i_halt so the pipeline does not
    // advance in the cycle that halt first appears.
    assign o_step = (state_q == ST_STEP) || ((state_q == ST_RUN) && !i_halt);
    assign o_busy = (state_q != ST_IDLE);

    assign o_debug_reg_num = regNum_q;
    assign o_debug_address = address_q;

    // Word source for the current dump section; sampled by the sender at the
    // end of LATCH, a full cycle after the selects were driven.
    always_comb begin
        dumpWord = '0;
        case (sec_q)
            SEC_PC:  dumpWord = i_pc;
            SEC_CYC: dumpWord = cycleCount_q;
            SEC_REG: dumpWord = i_reg_data;
            SEC_MEM: dumpWord = i_mem_data;
            default: dumpWord = '0;
        endcase
    end

    debug_word_sender #(
        .NB(NB)
    ) u_sender (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (state_q == ST_LATCH),
        .i_word      (dumpWord),
        .i_tx_done   (i_tx_done),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_word_done (wordDone)
    );

    // Controller FSM: command decode, stepping, and section/index walking.
    // Selects are updated on the transition into SEL so they are stable for
    // the whole SEL cycle before LATCH captures the read data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            sec_q        <= SEC_PC;
            idx_q        <= '0;
            cycleCount_q <= '0;
            regNum_q     <= '0;
            address_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sec_q     <= SEC_PC;
                    idx_q     <= '0;
                    regNum_q  <= '0;
                    address_q <= '0;
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_STEP: state_q <= ST_STEP;
                            CMD_RUN:  state_q <= i_halt ? ST_SEL : ST_RUN;
                            CMD_DUMP: state_q <= ST_SEL;
                            default:  state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_STEP: begin
                    cycleCount_q <= cycleCount_d;
                    state_q      <= ST_SEL;
                end
                ST_RUN: begin
                    if (i_halt) begin
                        state_q <= ST_SEL;
                    end else begin
                        cycleCount_q <= cycleCount_d;
                    end
                end
                ST_SEL: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (wordDone) begin
                        state_q <= ST_SEL;
                        case (sec_q)
                            SEC_PC: begin
                                sec_q <= SEC_CYC;
                            end
                            SEC_CYC: begin
                                sec_q    <= SEC_REG;
                                idx_q    <= '0;
                                regNum_q <= '0;
                            end
                            SEC_REG: begin
                                if (idx_q == LAST_REG) begin
                                    sec_q     <= SEC_MEM;
                                    idx_q     <= '0;
                                    address_q <= '0;
                                end else begin
                                    idx_q    <= idx_d;
                                    regNum_q <= idx_d[4:0];
                                end
                            end
                            SEC_MEM: begin
                                if (idx_q == LAST_MEM) begin
                                    state_q   <= ST_IDLE;
                                    idx_q     <= '0;
                                    regNum_q  <= '0;
                                    address_q <= '0;
                                end else begin
                                    idx_q     <= idx_d;
                                    address_q <= NB'({idx_d, 2'b00});
                                end
                            end
                            default: sec_q <= SEC_PC;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Debug controller that sequences the 5-stage MIPS pipeline from a byte-oriented host link (UART rx/tx handshake).
- Decodes single-byte commands.
- Drives the pipeline's step enable, in single-step or continuous run until halt.
- Walks the pipeline's debug selects (register number, memory address) to stream a state dump to the host: PC, cycle count, registers, data-memory words.
- Sits between the UART blocks and the pipeline top.

Parameters:
NB, 32, datapath word width
N_REGS, 32, registers dumped (numbers 0..N_REGS-1)
MEM_WORDS, 16, data-memory words dumped (byte addresses 0, 4, ..., 4*(MEM_WORDS-1))
CMD_STEP, 8'h73, ASCII 's': single step then dump
CMD_RUN, 8'h63, ASCII 'c': run until halt then dump
CMD_DUMP, 8'h64, ASCII 'd': dump only

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received byte
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
i_tx_done  in  1  one-cycle pulse: previous tx byte finished
i_halt  in  1  pipeline reached HALT (level)
i_pc  in  NB  pipeline PC
i_reg_data  in  NB  register file read for o_debug_reg_num
i_mem_data  in  NB  data-memory read for o_debug_address
o_step  out  1  pipeline step enable
o_debug_reg_num  out  5  register select
o_debug_address  out  NB  memory byte address select
o_tx_data  out  8  byte to send
o_tx_start  out  1  one-cycle pulse: send o_tx_data
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_reset=0, asynchronous) forces every output to 0, the state to IDLE and all counters to 0. Reset mid-run or mid-dump aborts immediately; no partial byte is completed.
- IDLE: wait for i_rx_done.
  - CMD_STEP: o_step=1 for exactly one cycle (STEP), cycle_count+1, then go to DUMP.
  - CMD_RUN with i_halt=0: go to RUN.
  - CMD_RUN with i_halt=1: go straight to DUMP; no step is issued.
  - CMD_DUMP: go to DUMP.
  - Any other byte: ignored.
- Bytes received while o_busy=1 are discarded.
- RUN: o_step=1 every cycle and cycle_count+1 per stepped cycle.
  - On the first cycle i_halt=1 is seen, o_step drops to 0 that same cycle (combinational gate on i_halt) and the state goes to DUMP.
  - Halt is not re-armed until the next command.
- cycle_count: NB-bit, wraps at 2^NB; cleared only by reset.
- DUMP word sequence:
  1. PC
  2. cycle_count
  3. reg 0..N_REGS-1
  4. mem word 0..MEM_WORDS-1
- Total bytes per dump = 4*(2+N_REGS+MEM_WORDS) = 200 with defaults.
- Per word:
  - SEL: drive o_debug_reg_num / o_debug_address (address = 4*index).
  - LATCH: one cycle later, capture the selected input into the shift register. This gives a one-cycle read latency allowance.
  - SEND: o_tx_start=1 for one cycle with byte = word[31:24].
  - WAIT: hold until i_tx_done, then send the next byte.
  - Bytes go out MSB first, 4 bytes per word.
- o_debug_reg_num and o_debug_address hold their value between words. They return to 0 in IDLE.
- After the last byte's i_tx_done, the state goes to IDLE.
- i_tx_done outside WAIT is ignored.
- Index counters must not overflow the select width; N_REGS<=32 is required.

Decomposition:
- Shared package (debug_pkg.vh): command byte constants, state encoding, dump section codes (SEC_PC, SEC_CYC, SEC_REG, SEC_MEM).
- One natural sub-module, debug_word_sender: latches an NB-bit word and sends 4 bytes over the tx handshake (start/done in, tx_start/tx_data out, word_done pulse).
- The top-level FSM handles command decode, stepping and section/index sequencing.

Test Plan:
1. Reset low mid-RUN, with o_step=1 -> o_step=0, o_busy=0, o_tx_start=0 in the same cycle; after release, IDLE and cycle_count=0.
2. Send 's' (8'h73) with PC=0x00000004, reg1=0x00000005 -> exactly one o_step cycle, then 200 tx bytes.
   - First 8 bytes: 00 00 00 04 00 00 00 01.
   - Reg1 bytes (offsets 12..15): 00 00 00 05.
3. Send 'c' and assert i_halt after 10 stepped cycles -> exactly 10 o_step cycles, no step in the halt cycle, cycle_count bytes 00 00 00 0A.
4. Send 'c' with i_halt already 1 -> no o_step pulse; dump starts; cycle_count unchanged.
5. During a dump, send 's' and 0x41 -> both ignored, dump byte count still 200, no extra o_step.
6. Mem model returning address+0x100: the word at index 15 reads 0x0000013C, o_debug_address=0x3C. Randomized i_tx_done delays of 1..50 cycles -> same byte stream, exactly one o_tx_start per i_tx_done.
